// File: rtl/bpu_pkg.sv
// bpu_pkg: shared types and constants for the branch prediction unit.
package bpu_pkg;
  localparam int BPU_PC_W  = 9;
  localparam int BPU_IDX_W = 4;
  localparam int BPU_TAG_W = BPU_PC_W - BPU_IDX_W - 2;
  localparam logic [1:0] CTR_SNT    = 2'b00;
  localparam logic [1:0] CTR_WNT    = 2'b01;
  localparam logic [1:0] CTR_WT     = 2'b10;
  localparam logic [1:0] CTR_ST     = 2'b11;
  localparam logic [1:0] ALUOP_JUMP = 2'b11;
  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    logic [1:0]           ctr;
    logic [BPU_PC_W-1:0]  target;
  } bpu_entry_t;
endpackage

// File: rtl/sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating direction counter.
module sat_counter2
  import bpu_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);
  always_comb
    ctr_next = taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                     : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: BHT/BTB lookup at fetch, branch resolution and mispredict detection at EX.
// Entry layout comes from bpu_pkg, so PC_W/IDX_W are expected to keep their package defaults.
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W  = BPU_PC_W,
  parameter int IDX_W = BPU_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [PC_W-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_reg1,
  input  logic             ex_branch,
  input  logic [1:0]       ex_aluop,
  input  logic             ex_cmp,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic [31:0]      ex_pc_four,
  output logic [31:0]      ex_target,
  output logic             ex_taken,
  output logic             ex_mispredict,
  output logic [31:0]      ex_redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);
  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;
  bpu_entry_t tbl_q [N];
  bpu_entry_t tbl_d [N];
  logic [CNT_W-1:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] ex_tag;
  bpu_entry_t if_e, ex_e, new_e;
  logic if_hit, ex_hit, jump, jalr, train;
  logic [31:0] pc_ext;
  logic [1:0] ctr_nx;
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_pc[1:0];
  always_comb begin
    if_idx         = if_pc[IDX_W+1:2];
    if_e           = tbl_q[if_idx];
    if_hit         = if_e.valid && (if_e.tag == if_pc[PC_W-1:IDX_W+2]);
    if_pred_taken  = if_hit && if_e.ctr[1];
    if_pred_target = if_pred_taken ? if_e.target : '0;
  end
  always_comb begin
    pc_ext         = 32'(ex_pc);
    jump           = ex_aluop == ALUOP_JUMP;
    jalr           = ex_branch && jump;
    ex_target      = (jalr ? ex_reg1 : pc_ext) + ex_imm;
    ex_taken       = ex_valid && ((ex_branch && ex_cmp) || jump);
    ex_pc_four     = pc_ext + 32'd4;
    ex_redirect_pc = ex_taken ? ex_target : ex_pc_four;
    ex_mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                     (ex_taken && ex_pred_taken && ex_target[PC_W-1:0] != ex_pred_target));
  end
  sat_counter2 u_ctr (.ctr(ex_e.ctr), .taken(ex_taken), .ctr_next(ctr_nx));
  always_comb begin
    train  = ex_valid && (ex_branch || jump);
    ex_idx = ex_pc[IDX_W+1:2];
    ex_tag = ex_pc[PC_W-1:IDX_W+2];
    ex_e   = tbl_q[ex_idx];
    ex_hit = ex_e.valid && (ex_e.tag == ex_tag);
    // A not-taken miss leaves the entry alone so it cannot evict a useful neighbour.
    new_e  = ex_hit   ? '{valid: 1'b1, tag: ex_e.tag, ctr: ctr_nx,
                          target: ex_taken ? ex_target[PC_W-1:0] : ex_e.target}
           : ex_taken ? '{valid: 1'b1, tag: ex_tag, ctr: CTR_WT, target: ex_target[PC_W-1:0]}
           : ex_e;
    tbl_d  = tbl_q;
    if (train) tbl_d[ex_idx] = new_e;
    branch_count_d     = branch_count_q + CNT_W'(train);
    mispredict_count_d = mispredict_count_q + CNT_W'(ex_mispredict);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tbl_q              <= '{default: '0};
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      tbl_q              <= tbl_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed self-checking bench for branch_predict_unit.
module tb_branch_predict_unit;
  localparam int PC_W = 9, CNT_W = 16;
  logic clk = 0, reset = 1;
  logic [PC_W-1:0] if_pc = '0, if_pred_target, ex_pc = '0, ex_pred_target = '0;
  logic if_pred_taken, ex_valid = 0, ex_branch = 0, ex_cmp = 0, ex_pred_taken = 0;
  logic [31:0] ex_imm = '0, ex_reg1 = '0, ex_pc_four, ex_target, ex_redirect_pc;
  logic [1:0] ex_aluop = '0;
  logic ex_taken, ex_mispredict;
  logic [CNT_W-1:0] branch_count, mispredict_count;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  branch_predict_unit dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_reg1(ex_reg1), .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_cmp(ex_cmp),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .ex_pc_four(ex_pc_four),
    .ex_target(ex_target), .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
    .ex_redirect_pc(ex_redirect_pc), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic ex_set(input logic v, input logic [PC_W-1:0] pc, input logic [31:0] imm,
                        input logic [31:0] reg1, input logic br, input logic [1:0] op,
                        input logic cmp, input logic pt, input logic [PC_W-1:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_imm = imm; ex_reg1 = reg1; ex_branch = br;
    ex_aluop = op; ex_cmp = cmp; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic look(input string tag, input logic [PC_W-1:0] pc, input logic t,
                      input logic [PC_W-1:0] tgt);
    if_pc = pc;
    #1;
    chk({tag, "_taken"}, 32'(if_pred_taken), 32'(t));
    chk({tag, "_target"}, 32'(if_pred_target), 32'(tgt));
  endtask
  task automatic counts(input string tag, input int bc, input int mc);
    chk({tag, "_bcnt"}, 32'(branch_count), 32'(bc));
    chk({tag, "_mcnt"}, 32'(mispredict_count), 32'(mc));
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    look("rst", 9'h010, 0, 0);
    counts("rst", 0, 0);
    ex_set(1, 9'h010, 32'h20, 0, 1, 2'b00, 1, 0, 0);
    look("beq_nobypass", 9'h010, 0, 0);
    chk("beq_target", ex_target, 32'h30);
    chk("beq_taken", 32'(ex_taken), 1);
    chk("beq_mispred", 32'(ex_mispredict), 1);
    chk("beq_redirect", ex_redirect_pc, 32'h30);
    chk("beq_pc4", ex_pc_four, 32'h14);
    tick();
    look("beq_trained", 9'h010, 1, 9'h030);
    counts("beq", 1, 1);
    for (int i = 0; i < 3; i++) begin
      ex_set(1, 9'h010, 32'h20, 0, 1, 2'b00, 1, 1, 9'h030);
      chk("taken_hit_mispred", 32'(ex_mispredict), 0);
      tick();
    end
    counts("sat", 4, 1);
    ex_set(1, 9'h010, 32'h20, 0, 1, 2'b00, 0, 1, 9'h030);
    chk("nt1_mispred", 32'(ex_mispredict), 1);
    chk("nt1_redirect", ex_redirect_pc, 32'h14);
    tick();
    look("nt1_still_taken", 9'h010, 1, 9'h030);
    ex_set(1, 9'h010, 32'h20, 0, 1, 2'b00, 0, 1, 9'h030);
    tick();
    look("nt2_predicts_nt", 9'h010, 0, 0);
    counts("nt2", 6, 3);
    ex_set(1, 9'h010, 32'h20, 0, 1, 2'b00, 1, 0, 0);
    tick();
    look("retrain", 9'h010, 1, 9'h030);
    counts("retrain", 7, 4);
    ex_set(1, 9'h110, 32'h10, 0, 1, 2'b00, 1, 0, 0);
    look("alias_old_entry", 9'h010, 1, 9'h030);
    chk("alias_target", ex_target, 32'h120);
    tick();
    look("alias_evicted", 9'h010, 0, 0);
    look("alias_new", 9'h110, 1, 9'h120);
    counts("alias", 8, 5);
    ex_set(1, 9'h040, 32'h8, 32'h100, 1, 2'b11, 0, 1, 9'h100);
    chk("jalr_target", ex_target, 32'h108);
    chk("jalr_taken", 32'(ex_taken), 1);
    chk("jalr_mispred", 32'(ex_mispredict), 1);
    chk("jalr_redirect", ex_redirect_pc, 32'h108);
    tick();
    look("jalr_trained", 9'h040, 1, 9'h108);
    counts("jalr", 9, 6);
    ex_set(1, 9'h080, 32'hFFFF_FFF0, 32'h100, 0, 2'b11, 0, 1, 9'h070);
    chk("jal_target", ex_target, 32'h70);
    chk("jal_mispred", 32'(ex_mispredict), 0);
    chk("jal_pc4", ex_pc_four, 32'h84);
    tick();
    look("jal_trained", 9'h080, 1, 9'h070);
    look("jal_evicts_jalr", 9'h040, 0, 0);
    counts("jal", 10, 6);
    ex_set(0, 9'h020, 32'h40, 0, 1, 2'b00, 1, 1, 9'h060);
    chk("inv_taken", 32'(ex_taken), 0);
    chk("inv_mispred", 32'(ex_mispredict), 0);
    chk("inv_redirect", ex_redirect_pc, 32'h24);
    tick();
    look("inv_no_train", 9'h020, 0, 0);
    counts("inv", 10, 6);
    look("pre_reset", 9'h110, 1, 9'h120);
    #2 reset = 1;
    look("async_reset", 9'h110, 0, 0);
    counts("async_reset", 0, 0);
    look("async_reset_jal", 9'h080, 0, 0);
    tick();
    reset = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
